box_renderer: RTL
=================

Name: box_renderer

Overview:
- Consumer end of the box-position stream produced by the location processor: takes (box_x, box_y, color) beats over a valid/ready handshake.
- Converts each beat into a per-pixel plot stream for the VGA frame-buffer writer.
- Each beat first erases the previously drawn box with the background colour, then draws the new box.
- Sits between the location processor and the VGA adapter.

Parameters:
- BOX_WIDTH, 9'd4, box width in pixels (>=1)
- BOX_HEIGHT, 9'd4, box height in pixels (>=1)
- SCREEN_WIDTH, 9'd160, visible columns; pixels at x >= SCREEN_WIDTH are clipped
- SCREEN_HEIGHT, 9'd120, visible rows; pixels at y >= SCREEN_HEIGHT are clipped
- BG_COLOR, 3'd0, colour used to erase

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- s_valid  in  1  input beat valid
- s_ready  out  1  block can accept a beat
- box_x  in  9  new box top-left x
- box_y  in  9  new box top-left y
- in_color  in  3  new box colour
- vga_x  out  9  pixel x
- vga_y  out  9  pixel y
- vga_color  out  3  pixel colour
- vga_plot  out  1  write strobe, one pixel per asserted cycle
- done  out  1  one-cycle pulse when a beat's erase+draw completes

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - state = IDLE, s_ready = 1, vga_plot = 0, done = 0
  - vga_x = vga_y = 0, vga_color = BG_COLOR
  - have_prev = 0, old_x = old_y = 0
- States: IDLE, ERASE, DRAW, DONE.
- IDLE:
  - s_ready = 1.
  - On s_valid & s_ready at edge T, latch new_x, new_y, new_color; clear cx = cy = 0.
  - Go to ERASE if have_prev and (new_x, new_y) != (old_x, old_y); else go to DRAW.
- ERASE:
  - s_ready = 0.
  - Each cycle output vga_x = old_x + cx, vga_y = old_y + cy, vga_color = BG_COLOR.
  - Raster order, row-major: cx increments; at cx = BOX_WIDTH-1, cx wraps to 0 and cy increments.
  - After pixel (BOX_WIDTH-1, BOX_HEIGHT-1): reset cx, cy and go to DRAW.
- DRAW:
  - Same scan over new_x/new_y with vga_color = new_color.
  - After the last pixel go to DONE.
- DONE:
  - done = 1 for exactly one cycle, vga_plot = 0, s_ready = 0.
  - old_x <= new_x, old_y <= new_y, have_prev <= 1; then go to IDLE.
- Output timing:
  - Pixel outputs are registered; the first pixel appears in the cycle after the handshake (T+1).
  - vga_plot = 1 for each scanned pixel unless clipped.
- Clipping:
  - Sums are 10-bit internally.
  - If x >= SCREEN_WIDTH or y >= SCREEN_HEIGHT: vga_plot = 0 for that cycle, but the cycle is still consumed (fixed timing).
- Latency per beat, N = BOX_WIDTH*BOX_HEIGHT:
  - With erase: 2N pixel cycles; done at T+2N+1.
  - Without erase: N pixel cycles; done at T+N+1.
  - s_ready returns high the cycle after done.
- Same position, new colour: erase skipped; box redrawn in the new colour.
- Beats offered while s_ready = 0 are not consumed. s_valid must be held by the producer; the block never drops or double-accepts a beat.
- Reset mid-ERASE/DRAW: next cycle is IDLE with all outputs at reset values, have_prev = 0. The next beat draws without erase.
- Outside ERASE/DRAW, vga_plot = 0.

Test Plan:
- First beat after reset (params 4/4/160/120): reset high 2 cycles, then s_valid = 1, box_x = 10, box_y = 20, in_color = 2 -> no erase; 16 plot cycles (10..13, 20..23) with colour 2, row-major; done pulses at T+17; s_ready = 0 during T+1..T+17.
- Move: second beat x = 11, y = 20, color = 2 -> 16 erase cycles at (10..13, 20..23) with colour 0, then 16 draw cycles at (11..14, 20..23); done at T+33.
- Same position, colour 5 -> no erase; 16 draw cycles with colour 5; done at T+17.
- Clipping (SCREEN_WIDTH = SCREEN_HEIGHT = 7, box 4x4): beat x = 5, y = 5 -> 16 scan cycles; vga_plot = 1 only for (5,5), (6,5), (5,6), (6,6); done still at T+17.
- Backpressure: s_valid held high continuously with changing data -> a beat is accepted only in cycles where s_ready = 1; consecutive boxes are separated by exactly one IDLE cycle after done; no beat is lost or repeated.
- Reset mid-DRAW: assert reset at pixel 7 -> the next cycle has vga_plot = 0 and s_ready = 1; the following beat draws with no erase.

Source files
------------

// File: rtl/box_renderer.sv
// box_renderer: turns (box_x, box_y, color) beats into a per-pixel plot
// stream. Each beat erases the previous box in the background colour
// (unless the position is unchanged), then draws the new box.
module box_renderer #(
  parameter logic [8:0] BOX_WIDTH     = 9'd4,
  parameter logic [8:0] BOX_HEIGHT    = 9'd4,
  parameter logic [8:0] SCREEN_WIDTH  = 9'd160,
  parameter logic [8:0] SCREEN_HEIGHT = 9'd120,
  parameter logic [2:0] BG_COLOR      = 3'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [8:0] box_x,
  input  logic [8:0] box_y,
  input  logic [2:0] in_color,
  output logic [8:0] vga_x,
  output logic [8:0] vga_y,
  output logic [2:0] vga_color,
  output logic       vga_plot,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

  state_t     state, state_n;
  logic [8:0] cx, cy, cx_n, cy_n;
  logic [8:0] new_x, new_y, old_x, old_y;
  logic [2:0] new_color;
  logic       have_prev;

  logic       accept;
  logic       last_px;
  logic       erase_needed;
  logic       scan;
  logic [8:0] base_x, base_y;
  logic [2:0] pix_color;
  logic [9:0] sum_x, sum_y;
  logic       pix_plot;

  assign accept       = s_valid & s_ready;
  assign last_px      = (cx == BOX_WIDTH - 9'd1) && (cy == BOX_HEIGHT - 9'd1);
  assign erase_needed = have_prev && ((box_x != old_x) || (box_y != old_y));

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and raster counter advance
  always_comb begin
    state_n = state;
    cx_n    = cx;
    cy_n    = cy;
    case (state)
      IDLE: begin
        if (accept) begin
          cx_n    = '0;
          cy_n    = '0;
          state_n = erase_needed ? ERASE : DRAW;
        end
      end
      ERASE, DRAW: begin
        if (last_px) begin
          cx_n    = '0;
          cy_n    = '0;
          state_n = (state == ERASE) ? DRAW : DONE;
        end else if (cx == BOX_WIDTH - 9'd1) begin
          cx_n = '0;
          cy_n = cy + 9'd1;
        end else begin
          cx_n = cx + 9'd1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake and next-pixel values; pixels are computed from the upcoming
  // state so they can be registered and appear one cycle after the handshake
  always_comb begin
    s_ready   = (state == IDLE);
    scan      = 1'b0;
    base_x    = old_x;
    base_y    = old_y;
    pix_color = BG_COLOR;
    case (state_n)
      ERASE: scan = 1'b1;
      DRAW: begin
        scan      = 1'b1;
        base_x    = (state == IDLE) ? box_x    : new_x;
        base_y    = (state == IDLE) ? box_y    : new_y;
        pix_color = (state == IDLE) ? in_color : new_color;
      end
      default: scan = 1'b0;
    endcase
    sum_x    = {1'b0, base_x} + {1'b0, cx_n};
    sum_y    = {1'b0, base_y} + {1'b0, cy_n};
    pix_plot = scan && (sum_x < {1'b0, SCREEN_WIDTH}) && (sum_y < {1'b0, SCREEN_HEIGHT});
  end

  // Beat latches, previous-box tracking and registered pixel outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      cx        <= '0;
      cy        <= '0;
      new_x     <= '0;
      new_y     <= '0;
      new_color <= '0;
      old_x     <= '0;
      old_y     <= '0;
      have_prev <= 1'b0;
      vga_x     <= '0;
      vga_y     <= '0;
      vga_color <= BG_COLOR;
      vga_plot  <= 1'b0;
      done      <= 1'b0;
    end else begin
      cx <= cx_n;
      cy <= cy_n;
      if (accept) begin
        new_x     <= box_x;
        new_y     <= box_y;
        new_color <= in_color;
      end
      if (state == DONE) begin
        old_x     <= new_x;
        old_y     <= new_y;
        have_prev <= 1'b1;
      end
      vga_x     <= scan ? sum_x[8:0] : '0;
      vga_y     <= scan ? sum_y[8:0] : '0;
      vga_color <= scan ? pix_color  : BG_COLOR;
      vga_plot  <= pix_plot;
      done      <= (state_n == DONE);
    end
  end

endmodule
